// File: rtl/pipe_reg_skid_pkg.sv
// Shared types for the skid-buffered pipeline stage.
package pipe_reg_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_ONE:  occ_of = 2'd1;
      ST_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_reg_skid_if.sv
// Valid/ready/data stream; master drives valid+data, slave drives ready.
interface pipe_reg_skid_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_skid_data_reg.sv
// Enabled data register with async active-low reset and sync clear (clear wins).
module pipe_data_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= RESET_VAL;
    else if (clr)  q <= RESET_VAL;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline register with 1-entry skid buffer, registered in_ready, flush and stall counter.
//  state    | meaning
//  ST_EMPTY | nothing held
//  ST_ONE   | head word in main
//  ST_TWO   | head in main, next word in skid; upstream blocked
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  pipe_reg_skid_if.slave     up,
  pipe_reg_skid_if.master    dn,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic             accept_in, accept_out;
  logic             main_en, main_from_skid, skid_en, clr;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic [CNT_W-1:0] stall_q;

  assign dn.valid   = (state_q != ST_EMPTY);
  assign up.ready   = in_ready_q;
  assign accept_in  = up.valid & in_ready_q;
  assign accept_out = dn.valid & dn.ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    clr            = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept_in) begin
          state_d = ST_ONE;
          main_en = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept_in && accept_out) begin
          main_en = 1'b1;
        end else if (accept_in) begin
          state_d = ST_TWO;
          skid_en = 1'b1;
        end else if (accept_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (accept_out) begin
          state_d        = ST_ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush discards any same-edge input; a same-edge output was already delivered
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
      clr     = 1'b1;
    end
  end

  assign main_d = main_from_skid ? skid_q : up.data;

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (main_en),
    .d       (main_d),
    .q       (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (skid_en),
    .d       (up.data),
    .q       (skid_q)
  );

  assign dn.data = main_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   stall_q <= '0;
    else if (dn.valid && !dn.ready && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
  end

  assign stall_cnt = stall_q;
  assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Randomised and directed checks of pipe_reg_skid against a queue-based reference model.
module tb_pipe_reg_skid;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_reg_skid_if #(.WIDTH(WIDTH)) up_if ();
  pipe_reg_skid_if #(.WIDTH(WIDTH)) dn_if ();

  pipe_reg_skid #(.WIDTH(WIDTH), .RESET_VAL('0), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model: the words held, in delivery order
  logic [WIDTH-1:0] mq[$];
  bit               m_rdy;
  int               m_stall;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy   = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_edge();
    bit ov, ai, ao;
    ov = (mq.size() > 0);
    ai = up_if.valid && m_rdy;
    ao = ov && dn_if.ready;
    if (ov && !dn_if.ready && m_stall < SAT) m_stall++;
    if (flush) mq.delete();
    else begin
      if (ao) void'(mq.pop_front());
      if (ai) mq.push_back(up_if.data);
    end
    m_rdy = (mq.size() < 2);
  endtask

  task automatic compare();
    chk("out_valid", 64'(dn_if.valid), 64'(mq.size() > 0));
    chk("in_ready",  64'(up_if.ready), 64'(m_rdy));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (mq.size() > 0) chk("out_data", dn_if.data, mq[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = ordy;
    flush       = fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(dn_if.valid), 64'd0);
    chk("rst_in_ready",  64'(up_if.ready), 64'd0);
    chk("rst_out_data",  dn_if.data, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    reset_n = 1'b1;
    step();
    chk("rst_release_in_ready", 64'(up_if.ready), 64'd1);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();

    // reset
    do_reset();

    // streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
      step();
      chk("stream_data", dn_if.data, 64'(i));
      chk("stream_in_ready", 64'(up_if.ready), 64'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // back-pressure: A,B fill the stage, C waits upstream
    drive(1'b1, 64'hA, 1'b0, 1'b0); step();
    drive(1'b1, 64'hB, 1'b0, 1'b0); step();
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_rdy0", 64'(up_if.ready), 64'd0);
    drive(1'b1, 64'hC, 1'b0, 1'b0); step(); step();
    chk("bp_head_a", dn_if.data, 64'hA);
    drive(1'b1, 64'hC, 1'b1, 1'b0); step();
    chk("bp_head_b", dn_if.data, 64'hB);
    step();
    chk("bp_head_c", dn_if.data, 64'hC);
    drive(1'b0, '0, 1'b1, 1'b0); step();
    chk("bp_stall", 64'(stall_cnt), 64'd3);

    // flush while two words held, with a word offered and downstream ready
    drive(1'b1, 64'h11, 1'b0, 1'b0); step();
    drive(1'b1, 64'h12, 1'b0, 1'b0); step();
    drive(1'b1, 64'hD, 1'b1, 1'b1); step();
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_valid", 64'(dn_if.valid), 64'd0);
    chk("fl_rdy", 64'(up_if.ready), 64'd1);
    chk("fl_data", dn_if.data, 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) begin
      step();
      chk("fl_no_d", 64'(dn_if.valid), 64'd0);
    end

    // stall counter saturation
    do_reset();
    drive(1'b1, 64'h55, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat_cnt", 64'(stall_cnt), 64'(SAT));
    step();
    chk("sat_hold", 64'(stall_cnt), 64'(SAT));

    // async reset mid-cycle with two words held
    drive(1'b1, 64'h77, 1'b0, 1'b0); step();
    chk("ar_occ", 64'(occupancy), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", 64'(dn_if.valid), 64'd0);
    chk("ar_rdy", 64'(up_if.ready), 64'd0);
    chk("ar_occ0", 64'(occupancy), 64'd0);
    chk("ar_data", dn_if.data, 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      step();
      chk("ar_no_data", 64'(dn_if.valid), 64'd0);
    end

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0);
      step();
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
